seq_divider: RTL

Parametrised multi-cycle integer divider for the execute stage, succeeding the fixed 32-bit IP-wrapped unsigned divider. It computes signed or unsigned quotient or remainder with a radix-2 restoring algorithm, one quotient bit per cycle. It handles divide-by-zero and signed overflow in two cycles, and keeps the level-style enabled/completed handshake that exec units already drive.

---
 rtl/divider_pkg.sv | 36 +++
 rtl/div_step.sv | 38 +++
 rtl/seq_divider.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg
// Shared types and helpers for the sequential integer divider.
//   div_op_t    : operation encoding, bit 0 = signed, bit 1 = remainder
//   div_state_t : controller states of seq_divider
//   abs_w       : conditional two's-complement negation, used both for
//                 operand magnitudes and for the final sign fix-up
// ---------------------------------------------------------------------------
package divider_pkg;

  // Widest operand the helper function supports; callers zero-extend into
  // this width and truncate the result back to their own WIDTH.
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    DIVU = 2'b00,
    DIV  = 2'b01,
    REMU = 2'b10,
    REM  = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Negation modulo 2**MAX_WIDTH; the low WIDTH bits of the result equal the
  // WIDTH-bit negation, so truncation by the caller gives the right answer.
  function automatic logic [MAX_WIDTH-1:0] abs_w(input logic [MAX_WIDTH-1:0] value,
                                                 input logic                 neg);
    return neg ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One radix-2 restoring division step (purely combinational).
//   rem      in  WIDTH  partial remainder
//   quo      in  WIDTH  dividend/quotient shift register
//   divisor  in  WIDTH  divisor magnitude
//   rem_next out WIDTH  partial remainder after this step
//   quo_next out WIDTH  quotient register after shifting in one bit
// ---------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  // The shifted remainder keeps the old remainder MSB, so divisors with the
  // top bit set still compare correctly. When the subtraction is taken its
  // result is below the divisor, so WIDTH bits always hold it.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted[WIDTH-1:0] - divisor;
    if (shifted >= {1'b0, divisor}) begin
      rem_next = trial;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multi-cycle signed/unsigned integer divider (restoring, one bit per cycle).
//   clk        in  1      clock, rising edge
//   rst        in  1      asynchronous active-high reset
//   a          in  WIDTH  dividend
//   b          in  WIDTH  divisor
//   op         in  2      DIVU=00, DIV=01, REMU=10, REM=11
//   enabled    in  1      request, held high until the result is consumed
//   c          out WIDTH  quotient or remainder
//   completed  out 1      c holds a valid result
//   busy       out 1      iterating or fixing up signs
// Divide-by-zero and signed overflow skip the iteration and finish in two
// cycles. Dropping enabled mid-operation aborts back to IDLE.
// ---------------------------------------------------------------------------
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             enabled,
  output logic [WIDTH-1:0] c,
  output logic             completed,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state, state_next;
  div_op_t          op_q, op_q_next;
  logic [WIDTH-1:0] rem, rem_next;
  logic [WIDTH-1:0] quo, quo_next;
  logic [WIDTH-1:0] dvs, dvs_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             qneg, qneg_next;
  logic             rneg, rneg_next;
  logic             special, special_next;
  logic [WIDTH-1:0] c_next;
  logic             completed_next;

  logic             signed_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] quo_fixed, rem_fixed;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Operand magnitudes are taken from the live inputs; they only matter on
  // the capturing edge in IDLE.
  assign signed_op = op[0];
  assign a_mag     = WIDTH'(abs_w(MAX_WIDTH'(a), signed_op & a[WIDTH-1]));
  assign b_mag     = WIDTH'(abs_w(MAX_WIDTH'(b), signed_op & b[WIDTH-1]));

  // Special-case results are preloaded with their final signs, so the
  // fix-up is bypassed for them.
  assign quo_fixed = WIDTH'(abs_w(MAX_WIDTH'(quo), qneg & ~special));
  assign rem_fixed = WIDTH'(abs_w(MAX_WIDTH'(rem), rneg & ~special));

  assign busy = (state == CALC) || (state == FIX);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= DIVU;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      special   <= 1'b0;
      c         <= '0;
      completed <= 1'b0;
    end else begin
      state     <= state_next;
      op_q      <= op_q_next;
      rem       <= rem_next;
      quo       <= quo_next;
      dvs       <= dvs_next;
      cnt       <= cnt_next;
      qneg      <= qneg_next;
      rneg      <= rneg_next;
      special   <= special_next;
      c         <= c_next;
      completed <= completed_next;
    end
  end

  // Next-state and datapath control. Everything holds by default; a low
  // enabled in CALC or FIX aborts without touching c or completed.
  always_comb begin
    state_next     = state;
    op_q_next      = op_q;
    rem_next       = rem;
    quo_next       = quo;
    dvs_next       = dvs;
    cnt_next       = cnt;
    qneg_next      = qneg;
    rneg_next      = rneg;
    special_next   = special;
    c_next         = c;
    completed_next = completed;

    case (state)
      IDLE: begin
        if (enabled) begin
          op_q_next = div_op_t'(op);
          dvs_next  = b_mag;
          qneg_next = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_next = signed_op & a[WIDTH-1];
          if (b == '0) begin
            special_next = 1'b1;
            quo_next     = '1;
            rem_next     = a;
            state_next   = FIX;
          end else if (signed_op && (a == MIN_VAL) && (b == '1)) begin
            special_next = 1'b1;
            quo_next     = MIN_VAL;
            rem_next     = '0;
            state_next   = FIX;
          end else begin
            special_next = 1'b0;
            rem_next     = '0;
            quo_next     = a_mag;
            cnt_next     = CW'(WIDTH);
            state_next   = CALC;
          end
        end
      end

      CALC: begin
        if (!enabled) begin
          state_next = IDLE;
        end else begin
          rem_next = step_rem;
          quo_next = step_quo;
          cnt_next = cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state_next = FIX;
          end
        end
      end

      FIX: begin
        if (!enabled) begin
          state_next = IDLE;
        end else begin
          c_next         = ((op_q == REMU) || (op_q == REM)) ? rem_fixed : quo_fixed;
          completed_next = 1'b1;
          state_next     = DONE;
        end
      end

      DONE: begin
        if (!enabled) begin
          completed_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
